// File: rtl/cov_pkg.sv
// Shared state encoding and error codes for the Cov sequencer
// and the Cov_Controllogic decoder.
package cov_pkg;

  typedef enum logic [4:0] {
    IDLE      = 5'd0,
    INIT1     = 5'd1,
    INIT2     = 5'd2,
    INIT3     = 5'd3,
    INIT4     = 5'd4,
    CHECK1    = 5'd5,
    CHECK2    = 5'd6,
    CHECK3    = 5'd7,
    CHECK4    = 5'd8,
    CHECK5    = 5'd9,
    CHECK6    = 5'd10,
    CHECK7    = 5'd11,
    CHECK8    = 5'd12,
    EXCHANGE1 = 5'd13,
    EXCHANGE2 = 5'd14,
    EXCHANGE3 = 5'd15,
    PRELOOP1  = 5'd16,
    PRELOOP2  = 5'd17,
    LOOP1     = 5'd18,
    LOOP2     = 5'd19,
    LOOP3     = 5'd20,
    LOOP4     = 5'd21,
    LOOP5     = 5'd22,
    LOOP6     = 5'd23,
    LOOP7     = 5'd24,
    LOOP8     = 5'd25,
    LOOP9     = 5'd26,
    LOOP10    = 5'd27,
    LOOP11    = 5'd28,
    END1      = 5'd29,
    END2      = 5'd30
  } state_e;

  localparam logic [4:0] ST_UNUSED = 5'b11111;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OPND = 2'd1;
  localparam logic [1:0] ERR_DIV  = 2'd2;
  localparam logic [1:0] ERR_ITER = 2'd3;

endpackage

// File: rtl/cov_div_watchdog.sv
// Divider-wait watchdog: counts cycles spent in a wait state
// and flags the last permitted cycle.
module cov_div_watchdog #(
  parameter int DIV_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic timeout
);

  localparam int W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(DIV_TIMEOUT - 1);

  logic [W-1:0] wdog_q;

  // Parks at LAST so a late div_done never sees a wrapped count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (clr) begin
      wdog_q <= '0;
    end else if (hold && wdog_q != LAST) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign timeout = hold && (wdog_q == LAST);

endmodule

// File: rtl/cov_sequencer.sv
// Cov datapath sequencer: state register, next-state logic,
// sticky error and LOOP1 iteration bookkeeping.
module cov_sequencer
  import cov_pkg::*;
#(
  parameter int DIV_TIMEOUT = 16,
  parameter int MAX_ITER    = 65535,
  parameter int ITER_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flag_s1,
  input  logic              flag_z1,
  input  logic              div_done,
  output logic [4:0]        state,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_SAT = '1;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_m_q, err_m_d;
  logic              fail;
  logic [1:0]        fail_code;
  logic              wd_clr, wd_hold, wd_tmo;

  assign wd_hold = (state_q == LOOP3) || (state_q == LOOP8);
  assign wd_clr  = ((state_d == LOOP3) || (state_d == LOOP8))
                   && (state_d != state_q);

  cov_div_watchdog #(
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .hold   (wd_hold),
    .timeout(wd_tmo)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    code_d    = code_q;
    iter_d    = iter_q;
    err_m_d   = err_m_q;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT1;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          iter_d  = '0;
          err_m_d = 1'b0;
        end
      end
      INIT1: state_d = INIT2;
      INIT2: state_d = INIT3;
      INIT3: state_d = INIT4;
      INIT4: begin
        err_m_d = flag_s1;
        state_d = CHECK1;
      end
      CHECK1: state_d = CHECK2;
      CHECK2: begin
        if (flag_s1 || err_m_q) begin
          fail      = 1'b1;
          fail_code = ERR_OPND;
        end else begin
          state_d = CHECK3;
        end
      end
      CHECK3: state_d = CHECK4;
      CHECK4: begin
        if (flag_z1) begin
          fail      = 1'b1;
          fail_code = ERR_OPND;
        end else begin
          state_d = CHECK5;
        end
      end
      CHECK5: state_d = CHECK6;
      CHECK6: begin
        if (flag_z1) begin
          fail      = 1'b1;
          fail_code = ERR_OPND;
        end else begin
          state_d = CHECK7;
        end
      end
      CHECK7: state_d = CHECK8;
      CHECK8: state_d = flag_s1 ? EXCHANGE1 : PRELOOP1;
      EXCHANGE1: state_d = EXCHANGE2;
      EXCHANGE2: state_d = EXCHANGE3;
      EXCHANGE3: state_d = PRELOOP1;
      PRELOOP1: state_d = PRELOOP2;
      PRELOOP2: state_d = LOOP1;
      LOOP1: begin
        if (iter_q == ITER_LIM) begin
          fail      = 1'b1;
          fail_code = ERR_ITER;
        end else begin
          state_d = LOOP2;
          if (iter_q != ITER_SAT) iter_d = iter_q + 1'b1;
        end
      end
      LOOP2: state_d = LOOP3;
      LOOP3: begin
        if (div_done) begin
          state_d = LOOP4;
        end else if (wd_tmo) begin
          fail      = 1'b1;
          fail_code = ERR_DIV;
        end
      end
      LOOP4: state_d = LOOP5;
      LOOP5: state_d = LOOP6;
      LOOP6: state_d = flag_s1 ? LOOP1 : LOOP7;
      LOOP7: state_d = LOOP8;
      LOOP8: begin
        if (div_done) begin
          state_d = LOOP9;
        end else if (wd_tmo) begin
          fail      = 1'b1;
          fail_code = ERR_DIV;
        end
      end
      LOOP9:  state_d = LOOP10;
      LOOP10: state_d = LOOP11;
      LOOP11: state_d = flag_z1 ? END1 : LOOP1;
      END1: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      END2: state_d = IDLE;
      default: begin
        state_d = IDLE;
        err_d   = 1'b1;
        code_d  = ERR_OPND;
      end
    endcase
    // err is visible in the same cycle END2 is presented
    if (fail) begin
      state_d = END2;
      err_d   = 1'b1;
      code_d  = fail_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      iter_q  <= '0;
      err_m_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      code_q  <= code_d;
      iter_q  <= iter_d;
      err_m_q <= err_m_d;
    end
  end

  assign state    = state_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign err_code = code_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_cov_sequencer.sv
// Directed vector bench for cov_sequencer (DIV_TIMEOUT=16,
// MAX_ITER=3) plus asynchronous-reset corner case.
module tb_cov_sequencer;
  import cov_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flag_s1, flag_z1, div_done;
  logic [4:0]  state;
  logic        busy, err;
  logic [1:0]  err_code;
  logic [15:0] iter_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        s1;
    logic        z1;
    logic        dd;
    logic [4:0]  st;
    logic        busy;
    logic        err;
    logic [1:0]  code;
    logic [15:0] iter;
  } vec_t;

  vec_t        vq[$];
  logic        e_err;
  logic [1:0]  e_code;
  logic [15:0] e_iter;

  cov_sequencer #(
    .DIV_TIMEOUT(16),
    .MAX_ITER   (3),
    .ITER_W     (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flag_s1 (flag_s1),
    .flag_z1 (flag_z1),
    .div_done(div_done),
    .state   (state),
    .busy    (busy),
    .err     (err),
    .err_code(err_code),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic add(input logic st_i, input logic s1,
                     input logic z1, input logic dd,
                     input state_e nst);
    vec_t v;
    v.start = st_i;
    v.s1    = s1;
    v.z1    = z1;
    v.dd    = dd;
    v.st    = nst;
    v.busy  = (nst != IDLE);
    v.err   = e_err;
    v.code  = e_code;
    v.iter  = e_iter;
    vq.push_back(v);
  endtask

  task automatic go(input state_e nst);
    add(1'b0, 1'b0, 1'b0, 1'b0, nst);
  endtask

  task automatic to_check4();
    e_err  = 1'b0;
    e_code = 2'd0;
    e_iter = 16'd0;
    add(1'b1, 1'b0, 1'b0, 1'b0, INIT1);
    go(INIT2);
    go(INIT3);
    go(INIT4);
    go(CHECK1);
    go(CHECK2);
    go(CHECK3);
    go(CHECK4);
  endtask

  task automatic to_check8();
    to_check4();
    go(CHECK5);
    go(CHECK6);
    go(CHECK7);
    go(CHECK8);
  endtask

  task automatic to_loop1();
    to_check8();
    go(PRELOOP1);
    go(PRELOOP2);
    go(LOOP1);
  endtask

  task automatic check_all(input string name, input logic [4:0] w_st,
                           input logic w_busy, input logic w_err,
                           input logic [1:0] w_code,
                           input logic [15:0] w_iter);
    checks++;
    if ({state, busy, err, err_code, iter_cnt} !==
        {w_st, w_busy, w_err, w_code, w_iter}) begin
      errors++;
      $display("FAIL %s: got state=%0d busy=%b err=%b code=%0d iter=%0d, want state=%0d busy=%b err=%b code=%0d iter=%0d",
               name, state, busy, err, err_code, iter_cnt,
               w_st, w_busy, w_err, w_code, w_iter);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    flag_s1  = 1'b0;
    flag_z1  = 1'b0;
    div_done = 1'b0;

    // 1: m=12 n=5, one pass, exit via END1; start mid-run ignored
    to_loop1();
    e_iter = 16'd1;
    go(LOOP2);
    go(LOOP3);
    go(LOOP3);
    add(1'b0, 1'b0, 1'b0, 1'b1, LOOP4);
    add(1'b1, 1'b0, 1'b0, 1'b0, LOOP5);
    go(LOOP6);
    go(LOOP7);
    go(LOOP8);
    add(1'b0, 1'b0, 1'b0, 1'b1, LOOP9);
    go(LOOP10);
    go(LOOP11);
    add(1'b0, 1'b0, 1'b1, 1'b0, END1);
    go(IDLE);

    // 2: m<0 seen at INIT4, flag dropped before CHECK2
    e_err  = 1'b0;
    e_code = 2'd0;
    e_iter = 16'd0;
    add(1'b1, 1'b0, 1'b0, 1'b0, INIT1);
    go(INIT2);
    go(INIT3);
    go(INIT4);
    add(1'b0, 1'b1, 1'b0, 1'b0, CHECK1);
    go(CHECK2);
    e_err  = 1'b1;
    e_code = 2'd1;
    go(END2);
    go(IDLE);
    go(IDLE);

    // 3: n==0 at CHECK4; the next start clears err
    to_check4();
    e_err  = 1'b1;
    e_code = 2'd1;
    add(1'b0, 1'b0, 1'b1, 1'b0, END2);
    go(IDLE);

    // 4: divider never answers in LOOP3
    to_loop1();
    e_iter = 16'd1;
    go(LOOP2);
    go(LOOP3);
    for (int k = 0; k < 15; k++) go(LOOP3);
    e_err  = 1'b1;
    e_code = 2'd2;
    go(END2);
    go(IDLE);

    // 5: iteration limit; first div_done lands on the timeout cycle
    to_loop1();
    for (int p = 1; p <= 3; p++) begin
      e_iter = 16'(p);
      go(LOOP2);
      go(LOOP3);
      if (p == 1) begin
        for (int k = 0; k < 15; k++) go(LOOP3);
      end
      add(1'b0, 1'b0, 1'b0, 1'b1, LOOP4);
      go(LOOP5);
      go(LOOP6);
      add(1'b0, 1'b1, 1'b0, 1'b0, LOOP1);
    end
    e_err  = 1'b1;
    e_code = 2'd3;
    go(END2);
    go(IDLE);

    // 6: exchange path to LOOP8, then asynchronous reset
    to_check8();
    add(1'b0, 1'b1, 1'b0, 1'b0, EXCHANGE1);
    add(1'b1, 1'b0, 1'b0, 1'b0, EXCHANGE2);
    go(EXCHANGE3);
    go(PRELOOP1);
    go(PRELOOP2);
    go(LOOP1);
    e_iter = 16'd1;
    go(LOOP2);
    go(LOOP3);
    add(1'b0, 1'b0, 1'b0, 1'b1, LOOP4);
    go(LOOP5);
    go(LOOP6);
    go(LOOP7);
    go(LOOP8);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 5'd0, 1'b0, 1'b0, 2'd0, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      start    = vq[i].start;
      flag_s1  = vq[i].s1;
      flag_z1  = vq[i].z1;
      div_done = vq[i].dd;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].st, vq[i].busy,
                vq[i].err, vq[i].code, vq[i].iter);
    end

    start    = 1'b0;
    flag_s1  = 1'b0;
    flag_z1  = 1'b0;
    div_done = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 5'd0, 1'b0, 1'b0, 2'd0, 16'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_held", 5'd0, 1'b0, 1'b0, 2'd0, 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst_start", 5'd1, 1'b1, 1'b0, 2'd0, 16'd0);
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
